// File: rtl/seq_div_pkg.sv
// Shared definitions for the seq_div sequential restoring divider:
// FSM states, the default operand width and the iteration counter width.
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // One extra bit lets the counter hold WIDTH itself without wrapping.
  function automatic int ctrWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// Combinational single iteration of the restoring divider: shift one dividend
// bit into the partial remainder, trial-subtract the divisor, emit a quotient bit.
module seq_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvdMsb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] remNext_o,
  output logic             qBit_o
);

  logic [WIDTH:0] trial;

  // The trial remainder is one bit wider than the operands so the compare
  // against the divisor can never overflow; the result always fits back in WIDTH.
  always_comb begin
    trial     = {rem_i, dvdMsb_i};
    qBit_o    = (trial >= {1'b0, dvs_i});
    remNext_o = qBit_o ? WIDTH'(trial - {1'b0, dvs_i}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock, RISC-V DIV/REM corner cases.
// Define SEQ_DIV_SIGNED_EN for two's complement operands; otherwise operands are unsigned.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             rdy,
  output logic             busy,
  output logic             dbz
);

  localparam int CW = ctrWidth(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    ctr_q, ctr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             zdiv_q, zdiv_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic             signA, signB;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH-1:0] stepRem;
  logic             stepBit;

`ifdef SEQ_DIV_SIGNED_EN
  assign signA = a[WIDTH-1];
  assign signB = b[WIDTH-1];
`else
  assign signA = 1'b0;
  assign signB = 1'b0;
`endif

  assign magA = signA ? -a : a;
  assign magB = signB ? -b : b;

  seq_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .dvdMsb_i (dvd_q[WIDTH-1]),
    .dvs_i    (dvs_q),
    .remNext_o(stepRem),
    .qBit_o   (stepBit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zdiv_q  <= zdiv_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  // The quotient is shifted into the low end of the dividend register as the
  // dividend bits leave its top, so dvd_q holds the raw quotient after WIDTH steps.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zdiv_d  = zdiv_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        // First DONE cycle publishes rdy; results were loaded on the FIX edge.
        if (state_q == DONE && busy_q) begin
          rdy_d  = 1'b1;
          busy_d = 1'b0;
        end else if (start && !busy_q) begin
          rdy_d  = 1'b0;
          busy_d = 1'b1;
          sa_d   = signA;
          sb_d   = signB;
          ctr_d  = '0;
          if (b == '0) begin
            zdiv_d  = 1'b1;
            rem_d   = a;
            dvd_d   = '0;
            dvs_d   = '0;
            state_d = FIX;
          end else begin
            zdiv_d  = 1'b0;
            rem_d   = '0;
            dvd_d   = magA;
            dvs_d   = magB;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = stepRem;
        dvd_d = {dvd_q[WIDTH-2:0], stepBit};
        ctr_d = ctr_q + CW'(1);
        if (ctr_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // The W-bit negate maps the signed overflow case to itself with no special handling.
        if (zdiv_q) begin
          q_d = '1;
          r_d = rem_q;
        end else begin
          q_d = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
          r_d = sa_q ? -rem_q : rem_q;
        end
        dbz_d   = zdiv_q;
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign q    = q_q;
  assign r    = r_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=16): directed and random divisions
// through a scoreboard, handshake timing, busy-start and mid-operation reset.
module tb_seq_div;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         rdy;
  logic         busy;
  logic         dbz;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  seq_div #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .rdy  (rdy),
    .busy (busy),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dbz = ed;
    e.lat = ed ? 2 : W + 2;
    return e;
  endfunction

  // Reference result from the simulator's own integer division.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy;
    if (y == '0) return mk('1, x, 1'b1);
`ifdef SEQ_DIV_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    return mk(W'(sx / sy), W'(sx % sy), 1'b0);
  endfunction

  // Called at a negedge; start is seen by the next posedge (edge E).
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checkOutput("accept_busy", {31'b0, busy}, 32'd1);
    checkOutput("accept_rdy", {31'b0, rdy}, 32'd0);
  endtask

  // n0 is the number of cycles already elapsed since edge E.
  task automatic collect(input string tag, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    if (rdy !== 1'b1) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_timeout observed=%0d cycles expected=%0d", tag, n, e.lat);
      return;
    end
    checkOutput({tag, "_q"}, {16'b0, q}, {16'b0, e.q});
    checkOutput({tag, "_r"}, {16'b0, r}, {16'b0, e.r});
    checkOutput({tag, "_dbz"}, {31'b0, dbz}, {31'b0, e.dbz});
    checkOutput({tag, "_lat"}, n, e.lat);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] x, y;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_q", {16'b0, q}, 32'd0);
    checkOutput("reset_r", {16'b0, r}, 32'd0);
    checkOutput("reset_rdy", {31'b0, rdy}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_dbz", {31'b0, dbz}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(16'd100, 16'd7, mk(16'h000E, 16'h0002, 1'b0));
    collect("div_100_7", 0);

    // Each following start lands in the cycle rdy is high.
`ifdef SEQ_DIV_SIGNED_EN
    applyStimulus(16'hFF9C, 16'h0007, mk(16'hFFF2, 16'hFFFE, 1'b0));
`else
    applyStimulus(16'hFF9C, 16'h0007, mk(16'h2484, 16'h0000, 1'b0));
`endif
    collect("div_neg100_7", 0);

`ifdef SEQ_DIV_SIGNED_EN
    applyStimulus(16'h0064, 16'hFFF9, mk(16'hFFF2, 16'h0002, 1'b0));
`else
    applyStimulus(16'h0064, 16'hFFF9, mk(16'h0000, 16'h0064, 1'b0));
`endif
    collect("div_100_neg7", 0);

    applyStimulus(16'h0005, 16'h0000, mk(16'hFFFF, 16'h0005, 1'b1));
    collect("div_5_0", 0);

    applyStimulus(16'hFFF0, 16'h0000, mk(16'hFFFF, 16'hFFF0, 1'b1));
    collect("div_fff0_0", 0);

`ifdef SEQ_DIV_SIGNED_EN
    applyStimulus(16'h8000, 16'hFFFF, mk(16'h8000, 16'h0000, 1'b0));
`else
    applyStimulus(16'h8000, 16'hFFFF, mk(16'h0000, 16'h8000, 1'b0));
`endif
    collect("div_overflow", 0);

`ifdef SEQ_DIV_SIGNED_EN
    applyStimulus(16'hFFFF, 16'h0002, mk(16'h0000, 16'hFFFF, 1'b0));
`else
    applyStimulus(16'hFFFF, 16'h0002, mk(16'h7FFF, 16'h0001, 1'b0));
`endif
    collect("div_ffff_2", 0);

    applyStimulus(16'h0000, 16'h0003, mk(16'h0000, 16'h0000, 1'b0));
    collect("div_0_3", 0);

    // rdy and the result must hold while no new start arrives.
    repeat (3) @(negedge clk);
    checkOutput("hold_rdy", {31'b0, rdy}, 32'd1);
    checkOutput("hold_q", {16'b0, q}, 32'd0);

    // A start pulse mid-operation must be ignored.
    applyStimulus(16'd1000, 16'd9, mk(16'd111, 16'd1, 1'b0));
    repeat (4) @(negedge clk);
    a     = 16'd77;
    b     = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("busy_start", 5);
    repeat (3) @(negedge clk);
    checkOutput("busy_start_idle", {31'b0, busy}, 32'd0);
    checkOutput("busy_start_q", {16'b0, q}, 32'd111);

    // Reset in the middle of an operation aborts it.
    applyStimulus(16'd500, 16'd3, mk(16'd166, 16'd2, 1'b0));
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_rdy", {31'b0, rdy}, 32'd0);
    checkOutput("abort_q", {16'b0, q}, 32'd0);
    checkOutput("abort_r", {16'b0, r}, 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(16'd500, 16'd3, mk(16'd166, 16'd2, 1'b0));
    collect("after_abort", 0);

    for (int i = 0; i < 6; i++) begin
      x = W'($urandom);
      y = (i % 2 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 16'hFFFF));
      if (i % 3 == 2) x[W-1] = 1'b1;
      e = model(x, y);
      applyStimulus(x, y, e);
      collect("random", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
